// File: rtl/display_scan_tx_pkg.sv
// Shared types and sizing helpers for the DisplayBuffer panel scanner.
package display_scan_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } scan_state_e;

  localparam int unsigned DEFAULT_BUFFER_SIZE = 256;
  localparam int unsigned DEFAULT_ROWS        = 8;
  localparam int unsigned ROW_WIDTH           = DEFAULT_BUFFER_SIZE / DEFAULT_ROWS;

  function automatic int unsigned row_width(input int unsigned size, input int unsigned rows);
    return size / rows;
  endfunction

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned row_cnt_w(input int unsigned rows);
    return cnt_w(rows);
  endfunction

  function automatic int unsigned bit_cnt_w(input int unsigned rw);
    return cnt_w(rw);
  endfunction

endpackage

// File: rtl/display_scan_tx_if.sv
// Shift-register LED panel signals plus frame status, as seen by the scanner and its consumer.
interface display_scan_tx_if #(
  parameter int unsigned ROWS = 8
);
  import display_scan_tx_pkg::row_cnt_w;

  logic                        SCLK;
  logic                        SDATA;
  logic                        LATCH;
  logic                        BLANK;
  logic [row_cnt_w(ROWS)-1:0]  ROW_SEL;
  logic                        FRAME_DONE;
  logic                        BUSY;

  modport master (
    output SCLK,
    output SDATA,
    output LATCH,
    output BLANK,
    output ROW_SEL,
    output FRAME_DONE,
    output BUSY
  );

  modport slave (
    input SCLK,
    input SDATA,
    input LATCH,
    input BLANK,
    input ROW_SEL,
    input FRAME_DONE,
    input BUSY
  );

endinterface

// File: rtl/display_scan_tx_bit_timer.sv
// HALF-cycle pacing timer for the panel shift clock; cleared by the scanner on every state change.
module display_bit_timer
  import display_scan_tx_pkg::*;
#(
  parameter int unsigned HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic half_tick,
  output logic bit_tick,
  output logic sclk_phase
);

  localparam int unsigned   TW   = cnt_w(HALF);
  localparam logic [TW-1:0] LAST = TW'(HALF - 1);

  logic [TW-1:0] tmr;
  logic          phase;

  assign half_tick  = (tmr == LAST);
  assign bit_tick   = half_tick & phase;
  assign sclk_phase = phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      tmr   <= '0;
      phase <= 1'b0;
    end else if (half_tick) begin
      tmr   <= '0;
      phase <= ~phase;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_tx.sv
// Snapshots the DisplayBuffer once per frame and serialises it row by row, MSB first,
// to a shift-register LED panel.
module display_scan_tx
  import display_scan_tx_pkg::*;
#(
  parameter int unsigned DisplayBufferSize = 256,
  parameter int unsigned ROWS              = 8,
  parameter int unsigned HALF              = 2
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic                         EN,
  input  logic [DisplayBufferSize-1:0] DisplayBuffer,
  display_scan_tx_if.master            panel
);

  localparam int unsigned    RW       = row_width(DisplayBufferSize, ROWS);
  localparam int unsigned    RCW      = row_cnt_w(ROWS);
  localparam int unsigned    BCW      = bit_cnt_w(RW);
  localparam logic [RCW-1:0] ROW_LAST = RCW'(ROWS - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(RW - 1);

  scan_state_e              state, state_n;
  logic [DisplayBufferSize-1:0] snap;
  logic [RW-1:0]            shreg;
  logic [RCW-1:0]           row;
  logic [RCW-1:0]           row_sel;
  logic [BCW-1:0]           bit_cnt;
  logic                     frame_done;

  logic do_load, do_shift, enter_latch, exit_latch;
  logic half_tick, bit_tick, sclk_phase;

  display_bit_timer #(
    .HALF(HALF)
  ) u_timer (
    .clk        (clk),
    .rst_n      (RESET),
    .clr        (state_n != state),
    .half_tick  (half_tick),
    .bit_tick   (bit_tick),
    .sclk_phase (sclk_phase)
  );

  always_comb begin
    state_n     = state;
    do_load     = 1'b0;
    do_shift    = 1'b0;
    enter_latch = 1'b0;
    exit_latch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (EN) state_n = LOAD;
      end
      LOAD: begin
        do_load = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (bit_tick) begin
          do_shift = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            enter_latch = 1'b1;
            state_n     = LATCH;
          end
        end
      end
      LATCH: begin
        if (half_tick) begin
          exit_latch = 1'b1;
          if (row == ROW_LAST) state_n = EN ? LOAD : IDLE;
          else                 state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Row 0 loads straight from the input because the snapshot is captured on that same edge.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      snap       <= '0;
      shreg      <= '0;
      row        <= '0;
      row_sel    <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= 1'b0;
      if (do_load) begin
        if (row == '0) begin
          snap  <= DisplayBuffer;
          shreg <= DisplayBuffer[RW-1:0];
        end else begin
          shreg <= snap[row*RW +: RW];
        end
        bit_cnt <= '0;
      end
      if (do_shift) begin
        shreg   <= {shreg[RW-2:0], 1'b0};
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end
      if (enter_latch) row_sel <= row;
      if (exit_latch) begin
        if (row == ROW_LAST) begin
          row        <= '0;
          frame_done <= 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

  assign panel.SCLK       = (state == SHIFT) & sclk_phase;
  assign panel.SDATA      = (state == SHIFT) & shreg[RW-1];
  assign panel.LATCH      = (state == LATCH);
  assign panel.BLANK      = !((state == LOAD) || (state == SHIFT));
  assign panel.ROW_SEL    = row_sel;
  assign panel.FRAME_DONE = frame_done;
  assign panel.BUSY       = (state != IDLE);

endmodule

// File: tb/tb_display_scan_tx.sv
// Randomised self-checking bench for display_scan_tx: panel traffic is decoded from the pins and
// compared with rows sliced straight out of the DisplayBuffer image.
module tb_display_scan_tx;

  localparam int unsigned SIZE      = 256;
  localparam int unsigned ROWS      = 8;
  localparam int unsigned HALF      = 2;
  localparam int unsigned RW        = SIZE / ROWS;
  localparam int unsigned ROW_CYC   = 1 + RW * 2 * HALF + HALF;
  localparam int unsigned FRAME_CYC = ROWS * ROW_CYC;

  logic            clk;
  logic            RESET;
  logic            EN;
  logic [SIZE-1:0] db;

  display_scan_tx_if #(.ROWS(ROWS)) pif ();

  display_scan_tx #(
    .DisplayBufferSize(SIZE),
    .ROWS(ROWS),
    .HALF(HALF)
  ) dut (
    .clk           (clk),
    .RESET         (RESET),
    .EN            (EN),
    .DisplayBuffer (db),
    .panel         (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pin-level decode of what the panel would see.
  int          cyc;
  logic        sclk_p, latch_p, busy_p, fd_p;
  logic [31:0] cur_word;
  int          cur_bits, latch_run, fd_long, first_rise;
  logic [31:0] row_words[$];
  int          row_bits[$];
  int          row_sels[$];
  int          latch_lens[$];
  int          fd_cycs[$];
  int          load_cycs[$];

  function automatic logic [31:0] model_row(input logic [SIZE-1:0] img, input int unsigned r);
    return img[r*RW +: RW];
  endfunction

  function automatic logic [SIZE-1:0] rand_image();
    logic [SIZE-1:0] img;
    for (int unsigned i = 0; i < SIZE / 32; i++) img[i*32 +: 32] = $urandom;
    return img;
  endfunction

  task automatic clear_mon();
    cyc = 0; sclk_p = 0; latch_p = 0; busy_p = 0; fd_p = 0;
    cur_word = '0; cur_bits = 0; latch_run = 0; fd_long = 0; first_rise = -1;
    row_words.delete(); row_bits.delete(); row_sels.delete();
    latch_lens.delete(); fd_cycs.delete(); load_cycs.delete();
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
    if (pif.SCLK && !sclk_p) begin
      cur_word = {cur_word[30:0], pif.SDATA};
      cur_bits++;
      if (first_rise < 0) first_rise = cyc;
    end
    if (pif.LATCH) begin
      if (!latch_p) begin
        row_words.push_back(cur_word);
        row_bits.push_back(cur_bits);
        row_sels.push_back(int'(pif.ROW_SEL));
        cur_bits  = 0;
        latch_run = 0;
      end
      latch_run++;
    end else if (latch_p) begin
      latch_lens.push_back(latch_run);
    end
    if (pif.FRAME_DONE) begin
      fd_cycs.push_back(cyc);
      if (fd_p) fd_long++;
    end
    if (pif.BUSY && !busy_p) load_cycs.push_back(cyc);
    sclk_p  = pif.SCLK;
    latch_p = pif.LATCH;
    busy_p  = pif.BUSY;
    fd_p    = pif.FRAME_DONE;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) sample();
  endtask

  task automatic wait_rows(input int unsigned n, input int unsigned budget);
    for (int unsigned k = 0; k < budget && row_sels.size() < int'(n); k++) sample();
  endtask

  task automatic wait_latch_lens(input int unsigned n, input int unsigned budget);
    for (int unsigned k = 0; k < budget && latch_lens.size() < int'(n); k++) sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    RESET = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    EN    = 1'b1;
    db    = rand_image();
    #44;
    total++; if (pif.BLANK !== 1'b1) begin bad++; $display("FAIL reset_blank: got %b want 1", pif.BLANK); end
    total++; if (pif.SCLK !== 1'b0 || pif.SDATA !== 1'b0 || pif.LATCH !== 1'b0) begin
      bad++; $display("FAIL reset_panel: got sclk=%b sdata=%b latch=%b want 0 0 0", pif.SCLK, pif.SDATA, pif.LATCH);
    end
    total++; if (pif.ROW_SEL !== 3'd0 || pif.FRAME_DONE !== 1'b0 || pif.BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_status: got rowsel=%0d fd=%b busy=%b want 0 0 0", pif.ROW_SEL, pif.FRAME_DONE, pif.BUSY);
    end
    @(negedge clk);
    clear_mon();
    RESET = 1'b1;
    sample();
    total++; if (pif.BUSY !== 1'b1) begin bad++; $display("FAIL release_busy: got %b want 1", pif.BUSY); end
    total++; if (pif.BLANK !== 1'b0 || pif.SCLK !== 1'b0) begin
      bad++; $display("FAIL release_load: got blank=%b sclk=%b want 0 0", pif.BLANK, pif.SCLK);
    end
  endtask

  task automatic test_single_row();
    db       = '0;
    db[31:0] = 32'hA500_0001;
    EN       = 1'b1;
    do_reset();
    wait_latch_lens(1, ROW_CYC + 20);
    total++; if (latch_lens.size() < 1) begin
      bad++; $display("FAIL row0_timeout: got %0d latches want 1", latch_lens.size());
    end
    total++; if (row_words[0] !== 32'hA500_0001) begin bad++; $display("FAIL row0_data: got %h want a5000001", row_words[0]); end
    total++; if (row_bits[0] != 32) begin bad++; $display("FAIL row0_sclk_count: got %0d want 32", row_bits[0]); end
    total++; if (latch_lens[0] != int'(HALF)) begin bad++; $display("FAIL row0_latch_len: got %0d want %0d", latch_lens[0], HALF); end
    total++; if (row_sels[0] != 0) begin bad++; $display("FAIL row0_rowsel: got %0d want 0", row_sels[0]); end
    total++; if (first_rise != load_cycs[0] + 1 + int'(HALF)) begin
      bad++; $display("FAIL first_sclk_rise: got %0d want %0d", first_rise - load_cycs[0], 1 + HALF);
    end
  endtask

  task automatic test_frame_timing();
    db = rand_image();
    EN = 1'b1;
    do_reset();
    run(2 * FRAME_CYC + 20);
    total++; if (fd_cycs.size() != 2 || load_cycs.size() != 1) begin
      bad++; $display("FAIL frame_done_count: got %0d pulses %0d loads want 2 1", fd_cycs.size(), load_cycs.size());
    end
    total++; if (fd_cycs[0] - load_cycs[0] != int'(FRAME_CYC)) begin
      bad++; $display("FAIL frame_first: got %0d want %0d", fd_cycs[0] - load_cycs[0], FRAME_CYC);
    end
    total++; if (fd_cycs[1] - fd_cycs[0] != int'(FRAME_CYC)) begin
      bad++; $display("FAIL frame_period: got %0d want %0d", fd_cycs[1] - fd_cycs[0], FRAME_CYC);
    end
    total++; if (fd_long != 0) begin bad++; $display("FAIL frame_done_width: got %0d long pulses want 0", fd_long); end
    total++; if (row_words.size() < 2 * ROWS) begin
      bad++; $display("FAIL frame_rows: got %0d want %0d", row_words.size(), 2 * ROWS);
    end
    for (int unsigned i = 0; i < 2 * ROWS; i++) begin
      total++; if (row_words[i] !== model_row(db, i % ROWS) || row_sels[i] != int'(i % ROWS) || row_bits[i] != int'(RW)) begin
        bad++; $display("FAIL frame_row%0d: got data=%h sel=%0d bits=%0d want %h %0d %0d",
                        i, row_words[i], row_sels[i], row_bits[i], model_row(db, i % ROWS), i % ROWS, RW);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [SIZE-1:0] old_img, new_img;
    logic [31:0]     want;
    old_img           = rand_image();
    old_img[255:224]  = '0;
    new_img           = old_img;
    new_img[255:224]  = '1;
    db = old_img;
    EN = 1'b1;
    do_reset();
    wait_rows(3, 4 * ROW_CYC);
    run(20);
    db = new_img;
    wait_rows(2 * ROWS, 2 * FRAME_CYC);
    total++; if (row_words.size() < 2 * ROWS) begin
      bad++; $display("FAIL snap_timeout: got %0d rows want %0d", row_words.size(), 2 * ROWS);
    end
    total++; if (row_words[ROWS-1] !== 32'h0) begin bad++; $display("FAIL snap_row7_old: got %h want 00000000", row_words[ROWS-1]); end
    total++; if (row_words[2*ROWS-1] !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL snap_row7_new: got %h want ffffffff", row_words[2*ROWS-1]);
    end
    for (int unsigned i = 0; i < 2 * ROWS; i++) begin
      want = (i < ROWS) ? model_row(old_img, i) : model_row(new_img, i - ROWS);
      total++; if (row_words[i] !== want) begin bad++; $display("FAIL snap_row%0d: got %h want %h", i, row_words[i], want); end
    end
  endtask

  task automatic test_en_deassert();
    db = rand_image();
    EN = 1'b1;
    do_reset();
    wait_rows(2, 3 * ROW_CYC);
    run(30);
    EN = 1'b0;
    for (int unsigned k = 0; k < FRAME_CYC && fd_cycs.size() == 0; k++) sample();
    run(10);
    total++; if (fd_cycs.size() != 1) begin bad++; $display("FAIL en_frame_done: got %0d pulses want 1", fd_cycs.size()); end
    total++; if (row_words.size() != ROWS) begin bad++; $display("FAIL en_rows: got %0d want %0d", row_words.size(), ROWS); end
    for (int unsigned i = 3; i < ROWS; i++) begin
      total++; if (row_words[i] !== model_row(db, i)) begin
        bad++; $display("FAIL en_row%0d: got %h want %h", i, row_words[i], model_row(db, i));
      end
    end
    run(300);
    total++; if (pif.BUSY !== 1'b0 || pif.BLANK !== 1'b1 || fd_cycs.size() != 1) begin
      bad++; $display("FAIL en_idle: got busy=%b blank=%b pulses=%0d want 0 1 1", pif.BUSY, pif.BLANK, fd_cycs.size());
    end
    EN = 1'b1;
    sample();
    total++; if (pif.BUSY !== 1'b1) begin bad++; $display("FAIL en_restart_busy: got %b want 1", pif.BUSY); end
    wait_rows(ROWS + 1, 2 * ROW_CYC);
    total++; if (row_sels[ROWS] != 0 || row_words[ROWS] !== model_row(db, 0)) begin
      bad++; $display("FAIL en_restart_row: got sel=%0d data=%h want 0 %h", row_sels[ROWS], row_words[ROWS], model_row(db, 0));
    end
  endtask

  task automatic test_reset_mid_shift();
    int unsigned k;
    db = rand_image();
    EN = 1'b1;
    do_reset();
    k = 0;
    while (!(row_sels.size() == 5 && cur_bits == 11) && k < 6 * ROW_CYC) begin
      sample();
      k++;
    end
    total++; if (!(row_sels.size() == 5 && cur_bits == 11)) begin
      bad++; $display("FAIL rst_mid_reach: got rows=%0d bits=%0d want 5 11", row_sels.size(), cur_bits);
    end
    #2;
    RESET = 1'b0;
    #1;
    total++; if (pif.SCLK !== 1'b0 || pif.SDATA !== 1'b0 || pif.LATCH !== 1'b0 || pif.BLANK !== 1'b1 ||
                 pif.ROW_SEL !== 3'd0 || pif.FRAME_DONE !== 1'b0 || pif.BUSY !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async: got sclk=%b sdata=%b latch=%b blank=%b sel=%0d fd=%b busy=%b want 0 0 0 1 0 0 0",
                      pif.SCLK, pif.SDATA, pif.LATCH, pif.BLANK, pif.ROW_SEL, pif.FRAME_DONE, pif.BUSY);
    end
    run(4);
    total++; if (fd_cycs.size() != 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", fd_cycs.size()); end
    clear_mon();
    RESET = 1'b1;
    wait_rows(1, ROW_CYC + 10);
    total++; if (load_cycs.size() < 1 || load_cycs[0] != 1) begin
      bad++; $display("FAIL rst_mid_restart_load: got %0d loads want first at cycle 1", load_cycs.size());
    end
    total++; if (row_sels[0] != 0 || row_words[0] !== model_row(db, 0)) begin
      bad++; $display("FAIL rst_mid_restart_row: got sel=%0d data=%h want 0 %h", row_sels[0], row_words[0], model_row(db, 0));
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_row();
    test_frame_timing();
    test_snapshot();
    test_en_deassert();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
